// File: rtl/mono_pkg.sv
// mono_pkg -- shared definitions for the mono_data_tx readout block.
//   Hit word field widths, serial word length, test-pattern constant,
//   readout FSM state encoding and the Gray-code helper.
package mono_pkg;

    localparam int COL_W  = 6;
    localparam int ROW_W  = 8;
    localparam int TS_W   = 6;
    localparam int WORD_W = COL_W + ROW_W + 2 * TS_W;   // 26

    localparam logic [WORD_W-1:0] TEST_PATTERN = 26'h2AAAAAA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FROZEN = 2'd1,
        ST_SHIFT  = 2'd2
    } state_t;

    function automatic logic [TS_W-1:0] gray(input logic [TS_W-1:0] x);
        return x ^ (x >> 1);
    endfunction

endpackage

// File: rtl/mono_hit_fifo.sv
// mono_hit_fifo -- synchronous hit buffer, DEPTH x W, first-word fall-through.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (pointers/count only)
//   push, wdata  : write request; ignored when full
//   pop          : read request; ignored when empty
//   rdata        : word at the head of the buffer (valid when count != 0)
//   count        : number of stored words, 0..DEPTH
module mono_hit_fifo
    import mono_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = WORD_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop  && (count != '0);
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the bookkeeping does.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mono_data_tx.sv
// mono_data_tx -- hit buffering and serial readout toward the DAQ receiver.
//   Hits are time-stamped with a Gray-coded 6-bit BX counter, buffered, and
//   shifted out MSB first, one 26-bit word per READ edge while FREEZE is held.
// Ports:
//   CLK40, nRST          : clock, asynchronous active-low reset
//   RST_GRAY             : synchronous clear of the BX counter
//   HIT_VALID/COL/ROW/TOT: hit injection; HIT_READY = buffer not full
//   FREEZE, READ         : readout control (edge sensitive)
//   TOKEN, DATA          : words pending / serial data
//   EN_TEST_PATTERN      : replace popped words with a fixed pattern
//   LOST_CNT             : saturating count of hits dropped while full
// Build option: MONO_DATA_TX_TEST_PATTERN_EN enables the test-pattern path.
module mono_data_tx
    import mono_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int WORD_BITS = 26
) (
    input  logic             CLK40,
    input  logic             nRST,
    input  logic             RST_GRAY,
    input  logic             HIT_VALID,
    input  logic [COL_W-1:0] HIT_COL,
    input  logic [ROW_W-1:0] HIT_ROW,
    input  logic [TS_W-1:0]  HIT_TOT,
    output logic             HIT_READY,
    input  logic             FREEZE,
    input  logic             READ,
    output logic             TOKEN,
    output logic             DATA,
    input  logic             EN_TEST_PATTERN,
    output logic [7:0]       LOST_CNT
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(WORD_BITS);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

    state_t               state, state_nxt;
    logic [TS_W-1:0]      bx;
    logic [TS_W-1:0]      te_bin;
    logic [WORD_BITS-1:0] hit_word;
    logic [WORD_BITS-1:0] fifo_word;
    logic [WORD_BITS-1:0] load_word;
    logic [WORD_BITS-1:0] sreg;
    logic [BW-1:0]        bit_cnt;
    logic [CW-1:0]        count, cnt_nxt;
    logic [CW-1:0]        frozen_cnt, frozen_nxt;
    logic                 push, pop, snap;
    logic                 freeze_d, read_d;
    logic                 freeze_rise, read_rise;

    // ---------------- hit capture ----------------
    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST)         bx <= '0;
        else if (RST_GRAY) bx <= '0;
        else               bx <= bx + TS_W'(1);
    end

    assign te_bin    = bx + HIT_TOT;   // wraps mod 64
    assign hit_word  = {HIT_COL, HIT_ROW, gray(bx), gray(te_bin)};
    assign HIT_READY = (count != FULL_CNT);
    assign push      = HIT_VALID && HIT_READY;

    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST)
            LOST_CNT <= '0;
        else if (HIT_VALID && !HIT_READY && LOST_CNT != 8'hFF)
            LOST_CNT <= LOST_CNT + 8'd1;
    end

    mono_hit_fifo #(.DEPTH(DEPTH), .W(WORD_BITS)) u_fifo (
        .clk   (CLK40),
        .rst_n (nRST),
        .push  (push),
        .wdata (hit_word),
        .pop   (pop),
        .rdata (fifo_word),
        .count (count)
    );

`ifdef MONO_DATA_TX_TEST_PATTERN_EN
    assign load_word = EN_TEST_PATTERN ? TEST_PATTERN : fifo_word;
`else
    logic unused_test_pattern;
    assign unused_test_pattern = EN_TEST_PATTERN;
    assign load_word = fifo_word;
`endif

    // ---------------- edge detectors ----------------
    // Tracked in every state so READ edges during SHIFT are consumed, not deferred.
    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) begin
            freeze_d <= 1'b0;
            read_d   <= 1'b0;
        end else begin
            freeze_d <= FREEZE;
            read_d   <= READ;
        end
    end

    assign freeze_rise = FREEZE && !freeze_d;
    assign read_rise   = READ && !read_d;

    // ---------------- readout FSM ----------------
    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (freeze_rise) state_nxt = ST_FROZEN;
            ST_FROZEN: begin
                if (!FREEZE)
                    state_nxt = ST_IDLE;
                else if (read_rise && frozen_cnt != '0)
                    state_nxt = ST_SHIFT;
            end
            // A falling FREEZE is honoured from FROZEN once the word is out.
            ST_SHIFT:  if (bit_cnt == LAST_BIT) state_nxt = ST_FROZEN;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        snap = (state == ST_IDLE) && freeze_rise;
        pop  = (state == ST_FROZEN) && FREEZE && read_rise && (frozen_cnt != '0);
        DATA = (state == ST_SHIFT) && sreg[WORD_BITS-1];
    end

    // ---------------- counters / shifter ----------------
    // Only the words present at the FREEZE edge are promised to the reader.
    always_comb begin
        frozen_nxt = frozen_cnt;
        if (snap)     frozen_nxt = count;
        else if (pop) frozen_nxt = frozen_cnt - CW'(1);
    end

    always_comb begin
        cnt_nxt = count;
        if (push && !pop)      cnt_nxt = count + CW'(1);
        else if (!push && pop) cnt_nxt = count - CW'(1);
    end

    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) begin
            frozen_cnt <= '0;
            sreg       <= '0;
            bit_cnt    <= '0;
            TOKEN      <= 1'b0;
        end else begin
            frozen_cnt <= frozen_nxt;
            if (pop) begin
                sreg    <= load_word;
                bit_cnt <= '0;
            end else if (state == ST_SHIFT) begin
                sreg    <= sreg << 1;
                bit_cnt <= bit_cnt + BW'(1);
            end
            // Built from next-cycle values so TOKEN tracks the state it describes.
            TOKEN <= (state_nxt == ST_IDLE) ? (cnt_nxt != '0) : (frozen_nxt != '0);
        end
    end

endmodule

// File: tb/tb_mono_data_tx.sv
module tb_mono_data_tx;
    logic       CLK40 = 1'b0;
    logic       nRST = 1'b0;
    logic       RST_GRAY = 1'b0;
    logic       HIT_VALID = 1'b0;
    logic [5:0] HIT_COL = '0;
    logic [7:0] HIT_ROW = '0;
    logic [5:0] HIT_TOT = '0;
    logic       HIT_READY;
    logic       FREEZE = 1'b0;
    logic       READ = 1'b0;
    logic       TOKEN;
    logic       DATA;
    logic       EN_TEST_PATTERN = 1'b0;
    logic [7:0] LOST_CNT;

    int tests = 0;
    int fails = 0;

    mono_data_tx #(.DEPTH(16), .WORD_BITS(26)) dut (
        .CLK40(CLK40), .nRST(nRST), .RST_GRAY(RST_GRAY),
        .HIT_VALID(HIT_VALID), .HIT_COL(HIT_COL), .HIT_ROW(HIT_ROW), .HIT_TOT(HIT_TOT),
        .HIT_READY(HIT_READY), .FREEZE(FREEZE), .READ(READ),
        .TOKEN(TOKEN), .DATA(DATA), .EN_TEST_PATTERN(EN_TEST_PATTERN),
        .LOST_CNT(LOST_CNT)
    );

    always #5 CLK40 = ~CLK40;

    task automatic tick();
        @(posedge CLK40);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_hit(input logic [5:0] c, input logic [7:0] r, input logic [5:0] t);
        HIT_VALID = 1'b1; HIT_COL = c; HIT_ROW = r; HIT_TOT = t;
        tick();
        HIT_VALID = 1'b0;
    endtask

    // One READ edge, then collect 26 serial bits; optionally keep pulsing READ.
    task automatic read_word(output logic [25:0] w, input bit pulse);
        w = '0;
        READ = 1'b1;
        tick();
        READ = 1'b0;
        for (int i = 0; i < 26; i++) begin
            w = {w[24:0], DATA};
            READ = pulse && (i % 5 == 2);
            tick();
        end
        READ = 1'b0;
    endtask

    logic [25:0] w;

    initial begin
        // reset state
        #12;
        chk("rst_ready", 32'(HIT_READY), 32'd1);
        chk("rst_token", 32'(TOKEN), 32'd0);
        chk("rst_data",  32'(DATA), 32'd0);
        chk("rst_lost",  32'(LOST_CNT), 32'd0);
        nRST = 1'b1;
        tick();

        // single hit at bx=10: col 5, row 100, LE=gray(10)=0F, TE=gray(13)=0B
        RST_GRAY = 1'b1; tick(); RST_GRAY = 1'b0;
        repeat (10) tick();
        push_hit(6'd5, 8'd100, 6'd3);
        chk("one_token_idle", 32'(TOKEN), 32'd1);
        FREEZE = 1'b1; tick();
        chk("one_token_frozen", 32'(TOKEN), 32'd1);
        read_word(w, 1'b0);
        chk("one_word", 32'(w), 32'h05643CB);
        chk("one_token_after", 32'(TOKEN), 32'd0);
        chk("one_data_after", 32'(DATA), 32'd0);
        FREEZE = 1'b0; tick();
        chk("one_token_idle_empty", 32'(TOKEN), 32'd0);

        // three hits frozen, two arrive after FREEZE; bx held at 0 (LE=0)
        RST_GRAY = 1'b1; tick();
        push_hit(6'd1,  8'd2,   6'd1);
        push_hit(6'd2,  8'd3,   6'd2);
        push_hit(6'd63, 8'd255, 6'd5);
        FREEZE = 1'b1; tick();
        push_hit(6'd10, 8'd20, 6'd0);
        push_hit(6'd11, 8'd21, 6'd3);
        read_word(w, 1'b0); chk("multi_w0", 32'(w), 32'({6'd1,  8'd2,   6'd0, 6'd1}));
        read_word(w, 1'b0); chk("multi_w1", 32'(w), 32'({6'd2,  8'd3,   6'd0, 6'd3}));
        chk("multi_token_mid", 32'(TOKEN), 32'd1);
        read_word(w, 1'b0); chk("multi_w2", 32'(w), 32'({6'd63, 8'd255, 6'd0, 6'd7}));
        chk("multi_token_done", 32'(TOKEN), 32'd0);
        READ = 1'b1; tick(); READ = 1'b0;
        chk("extra_read_data0", 32'(DATA), 32'd0);
        tick();
        chk("extra_read_data1", 32'(DATA), 32'd0);
        chk("extra_read_token", 32'(TOKEN), 32'd0);
        FREEZE = 1'b0; tick();
        chk("multi_token_remain", 32'(TOKEN), 32'd1);

        // READ pulses during SHIFT are ignored
        FREEZE = 1'b1; tick();
        read_word(w, 1'b1);
        chk("pulse_w3", 32'(w), 32'({6'd10, 8'd20, 6'd0, 6'd0}));
        chk("pulse_data_gap", 32'(DATA), 32'd0);
        chk("pulse_token", 32'(TOKEN), 32'd1);
        read_word(w, 1'b0);
        chk("pulse_w4", 32'(w), 32'({6'd11, 8'd21, 6'd0, 6'd2}));
        FREEZE = 1'b0; tick();
        chk("drained_token", 32'(TOKEN), 32'd0);

        // fill to DEPTH, then overflow
        HIT_VALID = 1'b1; HIT_COL = 6'd7; HIT_ROW = 8'd9; HIT_TOT = 6'd0;
        repeat (15) tick();
        chk("fill15_ready", 32'(HIT_READY), 32'd1);
        tick();
        chk("fill16_ready", 32'(HIT_READY), 32'd0);
        chk("fill16_lost", 32'(LOST_CNT), 32'd0);
        tick();
        chk("lost_one", 32'(LOST_CNT), 32'd1);
        repeat (300) tick();
        chk("lost_sat", 32'(LOST_CNT), 32'd255);
        HIT_VALID = 1'b0;

        // reset while shifting bit 12 (row[0] = 1)
        FREEZE = 1'b1; tick();
        READ = 1'b1; tick(); READ = 1'b0;
        repeat (13) tick();
        chk("bit12_before_rst", 32'(DATA), 32'd1);
        nRST = 1'b0; #1;
        chk("midrst_data", 32'(DATA), 32'd0);
        chk("midrst_token", 32'(TOKEN), 32'd0);
        chk("midrst_ready", 32'(HIT_READY), 32'd1);
        chk("midrst_lost", 32'(LOST_CNT), 32'd0);
        FREEZE = 1'b0;
        #3 nRST = 1'b1;
        tick(); tick();
        chk("postrst_token", 32'(TOKEN), 32'd0);
        chk("postrst_data", 32'(DATA), 32'd0);

        // test-pattern select
        RST_GRAY = 1'b1; tick();
        push_hit(6'd3, 8'd4, 6'd0);
        FREEZE = 1'b1; EN_TEST_PATTERN = 1'b1; tick();
        read_word(w, 1'b0);
`ifdef MONO_DATA_TX_TEST_PATTERN_EN
        chk("tp_word", 32'(w), 32'h2AAAAAA);
`else
        chk("tp_ignored_word", 32'(w), 32'({6'd3, 8'd4, 6'd0, 6'd0}));
`endif
        EN_TEST_PATTERN = 1'b0;
        FREEZE = 1'b0; tick();
        chk("tp_fifo_empty", 32'(TOKEN), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
